// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter.
// Arbitration modes and the starvation counter width.
package sram_arb_pkg;

  typedef enum logic {
    PREF_WR = 1'b0,
    PREF_RD = 1'b1
  } arb_state_e;

  localparam int ARB_RR       = 0;
  localparam int ARB_WR_PRI   = 1;
  localparam int STARVE_CNT_W = 8;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of write grants taken while a read waits.
// o_near flags the count one below the limit for next-state lookahead.
module arb_starve_cnt
  import sram_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_inc,
  input  logic                    i_clr,
  output logic [STARVE_CNT_W-1:0] o_cnt,
  output logic                    o_hit,
  output logic                    o_near
);

  localparam logic [STARVE_CNT_W-1:0] LIM =
    STARVE_CNT_W'(STARVE_MAX);
  localparam logic [STARVE_CNT_W-1:0] LIM_M1 =
    STARVE_CNT_W'(STARVE_MAX - 1);

  logic [STARVE_CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_hit  = (r_cnt == LIM);
  assign o_near = (r_cnt == LIM_M1);

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one 1RW SRAM between a write and a read requester.
// One grant per cycle; read data returns two cycles after the grant.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 8,
  parameter int ARB_MODE   = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                    clk_i,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic                    wr_valid_i,
  input  logic [ADDR_W-1:0]       wr_addr_i,
  input  logic [DATA_W-1:0]       wr_data_i,
  output logic                    wr_ready_o,
  input  logic                    rd_valid_i,
  input  logic [ADDR_W-1:0]       rd_addr_i,
  output logic                    rd_ready_o,
  output logic [DATA_W-1:0]       rd_data_o,
  output logic                    rd_data_valid_o,
  output logic                    sram_cs_n_o,
  output logic                    sram_wr_n_o,
  output logic [ADDR_W-1:0]       sram_addr_o,
  output logic [DATA_W-1:0]       sram_din_o,
  input  logic [DATA_W-1:0]       sram_dout_i,
  output logic [STARVE_CNT_W-1:0] starve_cnt_o
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;

  logic              w_en;
  logic              w_pref_rd;
  logic              w_contend;
  logic              w_wr_gnt;
  logic              w_rd_gnt;
  logic              w_inc;
  logic              w_hit;
  logic              w_near;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rd_pend;
  logic              r_rd_vld;
  logic [DATA_W-1:0] r_rd_data;

  // Reset also blocks grants so no command leaks out during reset.
  assign w_en      = en_i & ~rst;
  assign w_pref_rd = (r_state == PREF_RD);
  assign w_contend = wr_valid_i & rd_valid_i;

  assign w_wr_gnt = w_en & wr_valid_i
                  & (~rd_valid_i | ~w_pref_rd);
  assign w_rd_gnt = w_en & rd_valid_i
                  & (~wr_valid_i | w_pref_rd);

  assign w_inc = (ARB_MODE == ARB_WR_PRI)
               & w_wr_gnt & rd_valid_i;

  arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .i_clk  (clk_i),
    .i_rst  (rst),
    .i_inc  (w_inc),
    .i_clr  (w_rd_gnt),
    .o_cnt  (starve_cnt_o),
    .o_hit  (w_hit),
    .o_near (w_near)
  );

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_state <= PREF_WR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Switch to PREF_RD in the same cycle the limit is reached.
  always_comb begin
    w_state_nxt = r_state;
    if (ARB_MODE == ARB_RR) begin
      if (w_contend && (w_wr_gnt || w_rd_gnt)) begin
        w_state_nxt = w_wr_gnt ? PREF_RD : PREF_WR;
      end
    end else begin
      if (w_rd_gnt) begin
        w_state_nxt = PREF_WR;
      end else if (w_hit || (w_inc && w_near)) begin
        w_state_nxt = PREF_RD;
      end
    end
  end

  assign wr_ready_o  = w_wr_gnt;
  assign rd_ready_o  = w_rd_gnt;
  assign sram_cs_n_o = ~(w_wr_gnt | w_rd_gnt);
  assign sram_wr_n_o = ~w_wr_gnt;
  assign sram_din_o  = wr_data_i;
  assign sram_addr_o = w_wr_gnt ? wr_addr_i
                     : w_rd_gnt ? rd_addr_i
                     : r_addr;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_addr    <= '0;
      r_rd_pend <= 1'b0;
      r_rd_vld  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_addr    <= sram_addr_o;
      r_rd_pend <= w_rd_gnt;
      r_rd_vld  <= r_rd_pend;
      if (r_rd_pend) begin
        r_rd_data <= sram_dout_i;
      end
    end
  end

  assign rd_data_o       = r_rd_data;
  assign rd_data_valid_o = r_rd_vld;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench: stimulus queues expectations, a negedge monitor checks.
// Two instances cover write-priority and round-robin arbitration.
module tb_sram_port_arbiter;

  localparam int DW = 128;
  localparam int AW = 8;

  localparam int K_CMD   = 0;
  localparam int K_CNT   = 1;
  localparam int K_GNT   = 2;
  localparam int K_RR    = 3;
  localparam int K_RDATA = 4;
  localparam int K_EMPTY = 5;

  localparam logic [1:0] GW = 2'b10;
  localparam logic [1:0] GR = 2'b01;

  typedef struct {
    int          cyc;
    int          kind;
    logic [DW-1:0] exp;
  } chk_t;

  typedef struct {
    int          cyc;
    logic [DW-1:0] data;
  } rd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  logic          wp_wv = 1'b0;
  logic [AW-1:0] wp_wa = '0;
  logic [DW-1:0] wp_wd = '0;
  logic          wp_rv = 1'b0;
  logic [AW-1:0] wp_ra = '0;
  logic          wp_wrr, wp_rdr, wp_rdv;
  logic [DW-1:0] wp_rdata, wp_din, wp_dout;
  logic          wp_cs_n, wp_wr_n;
  logic [AW-1:0] wp_addr;
  logic [7:0]    wp_cnt;

  logic          rr_wv = 1'b0;
  logic          rr_rv = 1'b0;
  logic          rr_wrr, rr_rdr, rr_rdv;
  logic [DW-1:0] rr_rdata, rr_din;
  logic          rr_cs_n, rr_wr_n;
  logic [AW-1:0] rr_addr;
  logic [7:0]    rr_cnt;
  logic [DW-1:0] rr_dout = '0;

  logic [DW-1:0] mem [0:255];

  chk_t         q_chk[$];
  rd_t          q_rd[$];
  logic [1:0]   q_gwp[$];
  logic [1:0]   q_grr[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_port_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .ARB_MODE(1), .STARVE_MAX(4)
  ) u_dut_wp (
    .clk_i(clk), .rst(rst), .en_i(en),
    .wr_valid_i(wp_wv), .wr_addr_i(wp_wa),
    .wr_data_i(wp_wd), .wr_ready_o(wp_wrr),
    .rd_valid_i(wp_rv), .rd_addr_i(wp_ra),
    .rd_ready_o(wp_rdr), .rd_data_o(wp_rdata),
    .rd_data_valid_o(wp_rdv),
    .sram_cs_n_o(wp_cs_n), .sram_wr_n_o(wp_wr_n),
    .sram_addr_o(wp_addr), .sram_din_o(wp_din),
    .sram_dout_i(wp_dout), .starve_cnt_o(wp_cnt)
  );

  sram_port_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .ARB_MODE(0), .STARVE_MAX(4)
  ) u_dut_rr (
    .clk_i(clk), .rst(rst), .en_i(en),
    .wr_valid_i(rr_wv), .wr_addr_i(wp_wa),
    .wr_data_i(wp_wd), .wr_ready_o(rr_wrr),
    .rd_valid_i(rr_rv), .rd_addr_i(wp_ra),
    .rd_ready_o(rr_rdr), .rd_data_o(rr_rdata),
    .rd_data_valid_o(rr_rdv),
    .sram_cs_n_o(rr_cs_n), .sram_wr_n_o(rr_wr_n),
    .sram_addr_o(rr_addr), .sram_din_o(rr_din),
    .sram_dout_i(rr_dout), .starve_cnt_o(rr_cnt)
  );

  // Behavioural 1RW SRAM: read data one cycle after the command.
  always @(posedge clk) begin
    if (!wp_cs_n) begin
      if (!wp_wr_n) mem[wp_addr] <= wp_din;
      else          wp_dout <= mem[wp_addr];
    end
  end

  function automatic string kname(int k);
    case (k)
      K_CMD:   return "wp_sram_cmd";
      K_CNT:   return "wp_starve_cnt";
      K_GNT:   return "wp_rdy_rdy_vld";
      K_RR:    return "rr_rdy_rdy_csn";
      K_RDATA: return "wp_rd_data";
      default: return "queues_empty";
    endcase
  endfunction

  always @(negedge clk) begin
    chk_t          c;
    rd_t           r;
    logic [1:0]    g;
    logic [1:0]    e;
    logic [DW-1:0] act;
    if (wp_wrr || wp_rdr) begin
      g = {wp_wrr, wp_rdr};
      n_vec++;
      if (q_gwp.size() == 0) begin
        n_err++;
        $display("FAIL wp_grant cyc=%0d got=%b none expected",
                 cyc, g);
      end else begin
        e = q_gwp.pop_front();
        if (g !== e) begin
          n_err++;
          $display("FAIL wp_grant cyc=%0d got=%b exp=%b",
                   cyc, g, e);
        end
      end
    end
    if (rr_wrr || rr_rdr) begin
      g = {rr_wrr, rr_rdr};
      n_vec++;
      if (q_grr.size() == 0) begin
        n_err++;
        $display("FAIL rr_grant cyc=%0d got=%b none expected",
                 cyc, g);
      end else begin
        e = q_grr.pop_front();
        if (g !== e) begin
          n_err++;
          $display("FAIL rr_grant cyc=%0d got=%b exp=%b",
                   cyc, g, e);
        end
      end
    end
    if (wp_rdv) begin
      n_vec++;
      if (q_rd.size() == 0) begin
        n_err++;
        $display("FAIL rd_return cyc=%0d data=%0h none expected",
                 cyc, wp_rdata);
      end else begin
        r = q_rd.pop_front();
        if (r.cyc != cyc || wp_rdata !== r.data) begin
          n_err++;
          $display("FAIL rd_return cyc=%0d data=%0h exp cyc=%0d data=%0h",
                   cyc, wp_rdata, r.cyc, r.data);
        end
      end
    end
    while (q_chk.size() > 0 && q_chk[0].cyc <= cyc) begin
      c = q_chk.pop_front();
      case (c.kind)
        K_CMD:   act = DW'({wp_cs_n, wp_wr_n, wp_addr});
        K_CNT:   act = DW'(wp_cnt);
        K_GNT:   act = DW'({wp_wrr, wp_rdr, wp_rdv});
        K_RR:    act = DW'({rr_wrr, rr_rdr, rr_cs_n});
        K_RDATA: act = wp_rdata;
        default: act = DW'(q_gwp.size() + q_grr.size()
                           + q_rd.size());
      endcase
      n_vec++;
      if (c.cyc != cyc || act !== c.exp) begin
        n_err++;
        $display("FAIL %s cyc=%0d got=%0h exp=%0h (at cyc %0d)",
                 kname(c.kind), cyc, act, c.exp, c.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(int kind, logic [DW-1:0] v);
    chk_t c;
    c.cyc  = cyc;
    c.kind = kind;
    c.exp  = v;
    q_chk.push_back(c);
  endtask

  task automatic expect_rd(logic [DW-1:0] v);
    rd_t r;
    r.cyc  = cyc + 2;
    r.data = v;
    q_rd.push_back(r);
  endtask

  initial begin
    logic [1:0] pat_wp [10];
    int         pat_cnt [10];
    logic [1:0] rr_pat [5];
    logic [1:0] re_wp [3];
    logic [1:0] re_rr [3];
    pat_wp  = '{GW, GW, GW, GW, GR, GW, GW, GW, GW, GR};
    pat_cnt = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
    rr_pat  = '{GW, GR, GW, GR, GW};
    re_wp   = '{GW, GW, GR};
    re_rr   = '{GR, GW, GR};

    // Reset with both requests high: nothing may be granted.
    wp_wv = 1'b1;
    wp_rv = 1'b1;
    tick();
    expect_at(K_GNT, '0);
    expect_at(K_CNT, '0);
    expect_at(K_CMD, DW'(10'b11_0000_0000));
    expect_at(K_RDATA, '0);
    tick();
    rst   = 1'b0;
    wp_wv = 1'b0;
    wp_rv = 1'b0;

    for (int i = 0; i < 4; i++) begin
      tick();
      wp_wv = 1'b1;
      wp_wa = AW'(i);
      wp_wd = DW'(8'hA0 + i);
      q_gwp.push_back(GW);
      expect_at(K_CMD, DW'({2'b00, AW'(i)}));
    end
    tick();
    wp_wv = 1'b0;
    wp_rv = 1'b1;
    wp_ra = 8'd2;
    q_gwp.push_back(GR);
    expect_rd(DW'(8'hA2));
    expect_at(K_CMD, DW'({2'b01, 8'd2}));
    tick();
    wp_rv = 1'b0;
    expect_at(K_CMD, DW'({2'b11, 8'd2}));
    expect_at(K_GNT, '0);
    tick();
    tick();

    for (int i = 0; i < 3; i++) begin
      tick();
      wp_wv = 1'b1;
      wp_wa = AW'(5 + i);
      wp_wd = DW'(8'hB5 + i);
      q_gwp.push_back(GW);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      wp_wv = 1'b0;
      wp_rv = 1'b1;
      wp_ra = AW'(5 + i);
      q_gwp.push_back(GR);
      expect_rd(DW'(8'hB5 + i));
    end
    tick();
    wp_rv = 1'b0;
    tick();
    tick();

    // Write-priority contention, limit 4.
    for (int i = 0; i < 10; i++) begin
      tick();
      wp_wv = 1'b1;
      wp_wa = 8'h20;
      wp_wd = DW'(8'hC0 + i);
      wp_rv = 1'b1;
      wp_ra = 8'd2;
      q_gwp.push_back(pat_wp[i]);
      expect_at(K_CNT, DW'(pat_cnt[i]));
      if (pat_wp[i] == GR) expect_rd(DW'(8'hA2));
    end
    tick();
    wp_wv = 1'b0;
    wp_rv = 1'b0;
    expect_at(K_CNT, '0);
    tick();
    tick();

    // Round-robin contention: ends holding PREF_RD.
    for (int i = 0; i < 5; i++) begin
      tick();
      rr_wv = 1'b1;
      rr_rv = 1'b1;
      q_grr.push_back(rr_pat[i]);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      rr_wv = 1'b0;
      rr_rv = 1'b0;
      wp_wv = 1'b1;
      wp_rv = 1'b1;
      q_gwp.push_back(GW);
      expect_at(K_CNT, DW'(i));
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      en    = 1'b0;
      rr_wv = 1'b1;
      rr_rv = 1'b1;
      expect_at(K_GNT, '0);
      expect_at(K_CNT, DW'(2));
      expect_at(K_CMD, DW'({2'b11, 8'h20}));
      expect_at(K_RR, DW'(3'b001));
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      en = 1'b1;
      q_gwp.push_back(re_wp[i]);
      q_grr.push_back(re_rr[i]);
      expect_at(K_CNT, DW'(2 + i));
      if (re_wp[i] == GR) expect_rd(DW'(8'hA2));
    end
    tick();
    wp_wv = 1'b0;
    wp_rv = 1'b0;
    rr_wv = 1'b0;
    rr_rv = 1'b0;
    tick();
    tick();

    // Reset while a read is in flight drops its return.
    tick();
    wp_rv = 1'b1;
    wp_ra = 8'd2;
    q_gwp.push_back(GR);
    tick();
    rst   = 1'b1;
    wp_wv = 1'b1;
    expect_at(K_GNT, '0);
    expect_at(K_CNT, '0);
    expect_at(K_RDATA, '0);
    tick();
    expect_at(K_GNT, '0);
    expect_at(K_CMD, DW'(10'b11_0000_0000));
    tick();
    rst   = 1'b0;
    wp_wv = 1'b0;
    wp_rv = 1'b0;
    tick();
    expect_at(K_GNT, '0);
    tick();
    tick();
    expect_at(K_EMPTY, '0);
    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
